seg7_scan16: RTL
================

# seg7_scan16

Four-digit multiplexed hex display driver that sits directly downstream of the 16-bit loadable counter. It takes the counter's 16-bit count and ripple-carry output, snapshots the count once per scan frame, and drives a common-anode-style four-digit seven-segment display. The display shows uppercase/lowercase hex (0-9, A, b, C, d, E, F), with optional leading-zero blanking and a sticky overflow indicator. All outputs are registered so they can drive pads directly.

## Interface
- DIV, 16, clocks per digit slot (scan tick period); legal range 2..65535
- CLK  in  1  rising-edge clock, same clock as the counter
- nCLR  in  1  asynchronous, active-low reset
- Din  in  16  counter count value (counter Dout[15:0])
- RCO  in  1  counter ripple-carry out; sets the overflow flag
- HOLD  in  1  1 = freeze the snapshot (display keeps its current value)
- LZB  in  1  1 = enable leading-zero blanking
- CLR_OVF  in  1  synchronous clear of the overflow flag
- SEG  out  7  segment drive, active-high; SEG[0]=a .. SEG[6]=g
- DP  out  1  decimal point, active-high; overflow indicator
- DIG  out  4  digit enables, active-low; DIG[k] selects nibble k (DIG[0] = Din[3:0])

## Operation
- **Prescaler `pcnt`**
  - Width = clog2(DIV).
  - Counts 0..DIV-1.
  - Tick when pcnt==DIV-1; pcnt then wraps to 0.
- **Digit index `idx`** (2 bits)
  - Increments on tick and wraps 3→0.
  - One frame = 4×DIV clocks.
- **Snapshot `snap`** (16 bits)
  - On a tick with idx==3 and HOLD==0: snap ← Din.
  - HOLD==1 at that edge: snap is unchanged.
  - snap never changes mid-frame, so the display cannot tear.
- **Overflow flag `ovf`**
  - Sampled every clock: ovf ← RCO | (ovf & ~CLR_OVF).
  - If RCO and CLR_OVF are both high in the same cycle, the set wins.
- **Nibble select**: nib = snap[4·idx+3 : 4·idx].
- **Leading-zero blank**
  - Digit k (k=1..3) is blank when LZB==1 and snap[15:4k]==0.
  - Digit 0 is never blank.
- **Hex decode** (gfedcba):
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111
  - 4=1100110, 5=1101101, 6=1111101, 7=0000111
  - 8=1111111, 9=1101111, A=1110111, b=1111100
  - C=0111001, d=1011110, E=1111001, F=1110001
- **Output registers**, updated every clock from the current-cycle state:
  - Anti-ghost slot (pcnt==0) or blank digit: DIG ← 1111, SEG ← 0000000.
  - Otherwise: DIG ← ~(0001 << idx) and SEG ← hex(nib).
  - DP ← (idx==0) & ovf & (pcnt!=0).
- **Reset (nCLR low)**, asynchronous and immediate regardless of CLK:
  - pcnt=0, idx=0, snap=0000, ovf=0.
  - Outputs: DIG=1111, SEG=0000000, DP=0.
  - Reset asserted mid-frame aborts the frame; after release the scan restarts at digit 0 with snap=0.

## Timing
- After reset release, the first edge has pcnt=0, so outputs stay blank (DIG=1111).
- Digit 0 becomes visible on the output after the second edge (one-cycle output register latency).
- Each digit slot lasts DIV clocks:
  - 1 clock of all-off (anti-ghost).
  - Then DIV-1 clocks with the digit enabled.
- Snapshot update to display latency:
  - snap loads on the tick that ends digit 3.
  - The new value first appears on the output 2 edges later (the digit-0 enable).
- The first frame after reset displays 0000 (or a lone 0 with LZB=1).
- Din is first captured at the end of frame 0, i.e. 4×DIV clocks after reset release.
- RCO to DP:
  - ovf sets on the edge sampling RCO=1.
  - DP goes high during the next digit-0 enabled clock (not the anti-ghost clock).
- CLR_OVF takes effect on the next edge; DP drops one edge after ovf clears.
- HOLD is sampled only at the frame-end tick; HOLD pulses at any other time have no effect.
- LZB, RCO and CLR_OVF are sampled every clock; a change to LZB alters the output on the next edge.

## Test plan
- Run all scenarios with DIV=4 (frame = 16 clocks).
- **Reset:** assert nCLR mid-frame with Din=0xFFFF → DIG=1111, SEG=0000000, DP=0 immediately (before the next CLK edge).
- **Snapshot:** Din=0x1234, HOLD=0, LZB=0; run 2 frames → in frame 1:
  - digit0: SEG=1100110 (4), DIG=1110
  - digit1: SEG=1001111 (3), DIG=1101
  - digit2: SEG=1011011 (2), DIG=1011
  - digit3: SEG=0000110 (1), DIG=0111
  - exactly 1 all-off clock per slot.
- **Leading-zero blank:** LZB=1.
  - Din=0x0005 → only digit0 lights, SEG=1101101; DIG=1111 through the digit1-3 slots.
  - Din=0x0000 → digit0 shows 0111111.
  - Din=0x0A00 → digits 2, 1, 0 show A, 0, 0.
- **HOLD / no tearing:**
  - Snapshot 0x00FF; set HOLD=1; change Din to 0xABCD mid-frame → display stays 00FF.
  - Release HOLD → ABCD appears starting at the next frame's digit0.
- **Overflow:**
  - Pulse RCO for 1 clock → DP=1 only during enabled digit0 clocks, in every frame until CLR_OVF.
  - RCO=1 and CLR_OVF=1 in the same cycle → DP stays set.
  - CLR_OVF alone → DP=0 from the next digit0 slot.
- **Counter chain:** connect a live counter16 with nLOAD=1; wrap 0xFFFF→0x0000 → RCO sets DP, and the displayed value changes only at frame boundaries.

Source files
------------

// File: rtl/seg7_scan16_if.sv
// Display-driver bundle: counter-side inputs and registered pad outputs.
interface seg7_scan16_if;
  logic [15:0] Din;
  logic        RCO;
  logic        HOLD;
  logic        LZB;
  logic        CLR_OVF;
  logic [6:0]  SEG;
  logic        DP;
  logic [3:0]  DIG;

  modport master (
    output Din, RCO, HOLD, LZB, CLR_OVF,
    input  SEG, DP, DIG
  );

  modport slave (
    input  Din, RCO, HOLD, LZB, CLR_OVF,
    output SEG, DP, DIG
  );
endinterface

// File: rtl/seg7_scan16.sv
// Four-digit multiplexed hex display driver with per-frame snapshot,
// leading-zero blanking and a sticky overflow decimal point.
module seg7_scan16 #(
  parameter int unsigned DIV = 16
) (
  input  logic          CLK,
  input  logic          nCLR,
  seg7_scan16_if.slave  bus
);

  localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(DIV - 1);

  logic [PW-1:0] pcnt;
  logic [1:0]    idx;
  logic [15:0]   snap;
  logic          ovf;
  logic          tick;

  logic [3:0]    nib;
  logic          blank;
  logic [6:0]    hex_seg;
  logic [6:0]    seg_d, seg_q;
  logic [3:0]    dig_d, dig_q;
  logic          dp_d, dp_q;

  assign tick = (pcnt == PMAX);

  always_comb begin
    nib = snap[{idx, 2'b00} +: 4];
    blank = 1'b0;
    case (idx)
      2'd1:    blank = bus.LZB && (snap[15:4]  == '0);
      2'd2:    blank = bus.LZB && (snap[15:8]  == '0);
      2'd3:    blank = bus.LZB && (snap[15:12] == '0);
      default: blank = 1'b0;
    endcase
  end

  // Segment order is {g,f,e,d,c,b,a}.
  always_comb begin
    hex_seg = '0;
    case (nib)
      4'h0: hex_seg = 7'b0111111;
      4'h1: hex_seg = 7'b0000110;
      4'h2: hex_seg = 7'b1011011;
      4'h3: hex_seg = 7'b1001111;
      4'h4: hex_seg = 7'b1100110;
      4'h5: hex_seg = 7'b1101101;
      4'h6: hex_seg = 7'b1111101;
      4'h7: hex_seg = 7'b0000111;
      4'h8: hex_seg = 7'b1111111;
      4'h9: hex_seg = 7'b1101111;
      4'hA: hex_seg = 7'b1110111;
      4'hB: hex_seg = 7'b1111100;
      4'hC: hex_seg = 7'b0111001;
      4'hD: hex_seg = 7'b1011110;
      4'hE: hex_seg = 7'b1111001;
      4'hF: hex_seg = 7'b1110001;
      default: hex_seg = '0;
    endcase
  end

  // First clock of every slot is all-off so the previous digit cannot ghost.
  always_comb begin
    dig_d = '1;
    seg_d = '0;
    if (pcnt != '0 && !blank) begin
      dig_d = ~(4'b0001 << idx);
      seg_d = hex_seg;
    end
    dp_d = (idx == 2'd0) && ovf && (pcnt != '0);
  end

  always_ff @(posedge CLK or negedge nCLR) begin
    if (!nCLR) begin
      pcnt  <= '0;
      idx   <= '0;
      snap  <= '0;
      ovf   <= 1'b0;
      seg_q <= '0;
      dig_q <= '1;
      dp_q  <= 1'b0;
    end else begin
      ovf <= bus.RCO | (ovf & ~bus.CLR_OVF);
      if (tick) begin
        pcnt <= '0;
        idx  <= idx + 2'd1;
        if (idx == 2'd3 && !bus.HOLD)
          snap <= bus.Din;
      end else begin
        pcnt <= pcnt + 1'b1;
      end
      seg_q <= seg_d;
      dig_q <= dig_d;
      dp_q  <= dp_d;
    end
  end

  assign bus.SEG = seg_q;
  assign bus.DIG = dig_q;
  assign bus.DP  = dp_q;

endmodule
